// File: rtl/race_round_ctrl.sv
// Round controller for a first-signal detector: clears it, opens a gated race window,
// latches the winner or a timeout, hands the result over valid/ready, and keeps win counts.
module race_round_ctrl #(
   parameter int CLR_CYCLES = 2,
   parameter int TIMEOUT    = 16,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       req,
   output logic             det_rst,
   output logic [2:0]       det_in,
   input  logic [2:0]       det_y,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [2:0]       winner,
   output logic             timed_out,
   output logic [CNT_W-1:0] wins_a,
   output logic [CNT_W-1:0] wins_b,
   output logic [CNT_W-1:0] wins_c,
   output logic [CNT_W-1:0] rounds
);

   localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ARMED, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic [TO_W-1:0]   tcnt_q, tcnt_d;
   logic [2:0]        winner_q, winner_d;
   logic              timed_out_q, timed_out_d;
   logic [CNT_W-1:0]  wins_a_q, wins_a_d;
   logic [CNT_W-1:0]  wins_b_q, wins_b_d;
   logic [CNT_W-1:0]  wins_c_q, wins_c_d;
   logic [CNT_W-1:0]  rounds_q, rounds_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
   endfunction

   always_comb begin
      // NOTE: every *_d is given its hold value first, so no branch can leave one unassigned and infer a latch.
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      tcnt_d      = tcnt_q;
      winner_d    = winner_q;
      timed_out_d = timed_out_q;
      wins_a_d    = wins_a_q;
      wins_b_d    = wins_b_q;
      wins_c_d    = wins_c_q;
      rounds_d    = rounds_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_CLEAR;
               clr_cnt_d = '0;
            end
         end
         S_CLEAR: begin
            if (clr_cnt_q == CLR_LAST) begin
               state_d = S_ARMED;
               tcnt_d  = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         S_ARMED: begin
            // A locked winner beats a timeout landing on the same edge.
            if (det_y != 3'b000) begin
               state_d     = S_DONE;
               winner_d    = det_y;
               timed_out_d = 1'b0;
            end else if (tcnt_q == TO_LAST) begin
               state_d     = S_DONE;
               winner_d    = 3'b000;
               timed_out_d = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d  = S_IDLE;
               rounds_d = sat_inc(rounds_q, 1'b1);
               wins_a_d = sat_inc(wins_a_q, winner_q[0]);
               wins_b_d = sat_inc(wins_b_q, winner_q[1]);
               wins_c_d = sat_inc(wins_c_q, winner_q[2]);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
      if (rst) begin
         state_q     <= S_IDLE;
         clr_cnt_q   <= '0;
         tcnt_q      <= '0;
         winner_q    <= 3'b000;
         timed_out_q <= 1'b0;
         wins_a_q    <= '0;
         wins_b_q    <= '0;
         wins_c_q    <= '0;
         rounds_q    <= '0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         tcnt_q      <= tcnt_d;
         winner_q    <= winner_d;
         timed_out_q <= timed_out_d;
         wins_a_q    <= wins_a_d;
         wins_b_q    <= wins_b_d;
         wins_c_q    <= wins_c_d;
         rounds_q    <= rounds_d;
      end
   end

   // Detector stays out of reset through DONE so its lock (and the winner) stays stable.
   assign det_rst   = (state_q == S_ARMED) || (state_q == S_DONE);
   assign det_in    = (state_q == S_ARMED) ? req : 3'b000;
   assign busy      = (state_q != S_IDLE);
   assign res_valid = (state_q == S_DONE);
   assign winner    = winner_q;
   assign timed_out = timed_out_q;
   assign wins_a    = wins_a_q;
   assign wins_b    = wins_b_q;
   assign wins_c    = wins_c_q;
   assign rounds    = rounds_q;

endmodule
